// File: rtl/fa_pkg.sv
// Shared definitions for the full-adder BIST: FSM state encoding, pattern count
// and the golden full-adder model.
package fa_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } fa_state_t;

    localparam int unsigned NUM_PAT = 8;

    // Returns {carry,sum} for a 1-bit full adder.
    function automatic logic [1:0] fa_golden(input logic a, input logic b, input logic cin);
        return {1'b0, a} + {1'b0, b} + {1'b0, cin};
    endfunction

endpackage

// File: rtl/fa_bist_cmp.sv
// Registered comparator: on sample_en checks {carry,sum} against the golden model
// for pattern idx and accumulates the per-pattern failure map and error count.
module fa_bist_cmp
    import fa_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               sample_en,
    input  logic [2:0]         idx,
    input  logic               sum,
    input  logic               carry,
    output logic [NUM_PAT-1:0] fail_map,
    output logic [3:0]         err_count
);

    logic mismatch;

    always_comb begin
        mismatch = ({carry, sum} != fa_golden(idx[2], idx[1], idx[0]));
    end

    // Each pattern is sampled once per run, so err_count tops out at 8.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fail_map  <= '0;
            err_count <= '0;
        end else if (clear) begin
            fail_map  <= '0;
            err_count <= '0;
        end else if (sample_en && mismatch) begin
            fail_map[idx] <= 1'b1;
            err_count     <= err_count + 4'd1;
        end
    end

endmodule

// File: rtl/fa_bist_ctrl.sv
// BIST controller for the 1-bit full adder: walks all eight {a,b,cin} patterns,
// holds each for HOLD_CYCLES clocks and checks the adder on the last held cycle.
module fa_bist_ctrl
    import fa_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               sum,
    input  logic               carry,
    output logic               a,
    output logic               b,
    output logic               cin,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [NUM_PAT-1:0] fail_map,
    output logic [3:0]         err_count
);

    localparam int unsigned HW = (HOLD_CYCLES < 2) ? 1 : $clog2(HOLD_CYCLES);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [2:0]    IDX_LAST  = 3'(NUM_PAT - 1);

    if (HOLD_CYCLES < 2) begin : g_bad_hold
        $error("fa_bist_ctrl: HOLD_CYCLES must be >= 2");
    end
    if (NUM_PAT != 8) begin : g_bad_npat
        $error("fa_bist_ctrl: NUM_PAT must be 8");
    end

    fa_state_t       state;
    logic [2:0]      idx;
    logic [HW-1:0]   hold;
    logic            sample_en;
    logic            clear;

    always_comb begin
        sample_en = (state == DRIVE) && (hold == HOLD_LAST);
        clear     = start && (state != DRIVE);
        pass      = done && (fail_map == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            hold          <= '0;
            {a, b, cin}   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state       <= DRIVE;
                        idx         <= '0;
                        hold        <= '0;
                        {a, b, cin} <= '0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                    end
                end
                DRIVE: begin
                    if (hold == HOLD_LAST) begin
                        hold <= '0;
                        if (idx == IDX_LAST) begin
                            state       <= DONE;
                            {a, b, cin} <= '0;
                            busy        <= 1'b0;
                            done        <= 1'b1;
                        end else begin
                            idx         <= idx + 3'd1;
                            {a, b, cin} <= idx + 3'd1;
                        end
                    end else begin
                        hold <= hold + HW'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

    fa_bist_cmp u_cmp (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .sample_en (sample_en),
        .idx       (idx),
        .sum       (sum),
        .carry     (carry),
        .fail_map  (fail_map),
        .err_count (err_count)
    );

endmodule

// File: tb/tb_fa_bist_ctrl.sv
// Bench for fa_bist_ctrl: a behavioural full adder with selectable fault injection
// sits on the a/b/cin -> sum/carry loop; results are checked against bench models.
module tb_fa_bist_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       sum, carry;
    logic       a, b, cin;
    logic       busy, done, pass;
    logic [7:0] fail_map;
    logic [3:0] err_count;

    // 0 good, 1 carry stuck-at-0, 2 sum inverted, 3 random per-pattern corruption,
    // 4 both outputs inverted while glitch is high
    int         mode;
    logic [1:0] corrupt [8];
    logic       glitch;
    logic [1:0] fa_out;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        fa_out = 2'(int'(a) + int'(b) + int'(cin));
        case (mode)
            1: fa_out[1] = 1'b0;
            2: fa_out[0] = ~fa_out[0];
            3: fa_out = fa_out ^ corrupt[{a, b, cin}];
            4: if (glitch) fa_out = ~fa_out;
            default: ;
        endcase
    end
    assign {carry, sum} = fa_out;

    fa_bist_ctrl #(.HOLD_CYCLES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .sum       (sum),
        .carry     (carry),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .fail_map  (fail_map),
        .err_count (err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulses start, follows the run to completion. Optionally re-pulses start at
    // busy cycles 1, 20 and 32 (all must be ignored).
    task automatic run(input bit pulses, output int ncyc, output bit seq_ok);
        int k;
        int guard;
        k      = 0;
        guard  = 0;
        seq_ok = 1'b1;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        while (busy === 1'b1 && guard < 100) begin
            k++;
            if ({a, b, cin} !== 3'((k - 1) / 4)) seq_ok = 1'b0;
            glitch = ((k - 1) % 4) != 3;
            start  = pulses && (k == 1 || k == 20 || k == 32);
            tick();
            guard++;
        end
        start  = 1'b0;
        glitch = 1'b0;
        ncyc   = k;
    endtask

    int         ncyc;
    bit         seq_ok;
    logic [7:0] exp_map;
    logic [3:0] exp_cnt;

    initial begin
        rst_n  = 1'b0;
        start  = 1'b0;
        mode   = 0;
        glitch = 1'b0;
        for (int i = 0; i < 8; i++) corrupt[i] = 2'b00;

        tick();
        tick();
        chk("reset_outputs", {busy, done, pass, a, b, cin, fail_map, err_count}, 0);
        rst_n = 1'b1;
        tick();
        chk("idle_outputs", {busy, done, pass, a, b, cin, fail_map, err_count}, 0);

        // Good adder
        mode = 0;
        run(1'b0, ncyc, seq_ok);
        chk("good_busy_cycles", ncyc, 32);
        chk("good_sequence", seq_ok, 1);
        chk("good_done", done, 1);
        chk("good_pass", pass, 1);
        chk("good_fail_map", fail_map, 8'h00);
        chk("good_err_count", err_count, 0);
        chk("good_abc_done", {a, b, cin}, 3'b000);

        // Carry stuck-at-0
        mode = 1;
        run(1'b0, ncyc, seq_ok);
        chk("csa0_fail_map", fail_map, 8'hE8);
        chk("csa0_err_count", err_count, 4);
        chk("csa0_pass", pass, 0);
        chk("csa0_done", done, 1);

        // Sum inverted
        mode = 2;
        run(1'b0, ncyc, seq_ok);
        chk("suminv_fail_map", fail_map, 8'hFF);
        chk("suminv_err_count", err_count, 8);
        chk("suminv_pass", pass, 0);

        // Start in DONE: done drops and results clear on the next cycle
        mode  = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_done", done, 0);
        chk("restart_fail_map", fail_map, 8'h00);
        chk("restart_err_count", err_count, 0);
        chk("restart_busy", busy, 1);
        for (int i = 0; i < 40 && busy === 1'b1; i++) tick();
        chk("restart_pass", pass, 1);

        // Reset during pattern 4, mid-hold
        mode  = 2;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 17; i++) tick();
        chk("mid_pattern4", {a, b, cin}, 3'b100);
        chk("mid_partial_map", fail_map, 8'h0F);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", {busy, done, pass, a, b, cin, fail_map, err_count}, 0);
        tick();
        rst_n = 1'b1;
        tick();
        mode = 0;
        run(1'b0, ncyc, seq_ok);
        chk("post_abort_cycles", ncyc, 32);
        chk("post_abort_pass", pass, 1);

        // Starts while busy (including on the final sample) are ignored
        mode = 1;
        run(1'b1, ncyc, seq_ok);
        chk("ignore_start_cycles", ncyc, 32);
        chk("ignore_start_sequence", seq_ok, 1);
        tick();
        chk("ignore_start_done", done, 1);
        chk("ignore_start_map", fail_map, 8'hE8);

        // Faults only on the first three cycles of each pattern are never sampled
        mode = 4;
        run(1'b0, ncyc, seq_ok);
        chk("glitch_sequence", seq_ok, 1);
        chk("glitch_fail_map", fail_map, 8'h00);
        chk("glitch_pass", pass, 1);

        // Random per-pattern corruption against the bench model
        mode = 3;
        for (int r = 0; r < 6; r++) begin
            exp_map = '0;
            exp_cnt = '0;
            for (int i = 0; i < 8; i++) begin
                corrupt[i] = 2'($urandom_range(0, 3));
                if (corrupt[i] != 2'b00) begin
                    exp_map[i] = 1'b1;
                    exp_cnt    = exp_cnt + 4'd1;
                end
            end
            for (int w = $urandom_range(0, 5); w > 0; w--) tick();
            run(1'b0, ncyc, seq_ok);
            chk($sformatf("rand%0d_cycles", r), ncyc, 32);
            chk($sformatf("rand%0d_fail_map", r), fail_map, exp_map);
            chk($sformatf("rand%0d_err_count", r), err_count, exp_cnt);
            chk($sformatf("rand%0d_pass", r), pass, (exp_map == 8'h00));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
